arp_reply_parser: RTL and testbench
===================================

# arp_reply_parser

Learning side of the ARP path: consumes Ethernet frames from the receive Avalon-ST stream, recognises valid IPv4-over-Ethernet ARP replies addressed to this host, and emits one (IP, MAC) cache-update transaction per accepted frame. It is the writer for `arp_cache`, whose lookups the dataplane performs on the query side. It sits between the MAC RX stream tap and the cache's update port.

## Interface

- `ACCEPT_REQUEST`, default 0: when 1, ARP requests (oper=1) are also learned from their sender fields.
- `clk` input 1: single clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data_i` input 32: frame data, big-endian; first byte in [31:24].
- `rx_valid_i` input 1: beat valid.
- `rx_sop_i` input 1: start of packet.
- `rx_eop_i` input 1: end of packet.
- `rx_empty_i` input 2: empty bytes on EOP beat.
- `rx_error_i` input 6: nonzero on EOP beat marks the frame bad.
- `rx_ready_o` output 1: beat accepted when valid & ready.
- `cfg_local_ip_i` input 32: this host's IPv4 address; TPA must match.
- `upd_valid_o` output 1: update pending.
- `upd_ready_i` input 1: cache accepts update.
- `upd_ip_o` output 32: sender protocol address (SPA).
- `upd_mac_o` output 48: sender hardware address (SHA).
- `cnt_accepted_o` output 32: frames producing an update, wraps.
- `cnt_dropped_o` output 32: completed frames not producing an update, wraps.

## Operation

- Word map (index from SOP): w3 = {ethertype, htype}; w4 = {ptype, hlen, plen}; w5 = {oper, SHA[47:32]}; w6 = SHA[31:0]; w7 = SPA; w9[15:0] = TPA[31:16]; w10[31:16] = TPA[15:0]. Words beyond w10 (padding) are ignored.
- Checks: w3 == 32'h0806_0001; w4 == 32'h0800_0604; oper == 2 (or 1 when ACCEPT_REQUEST=1); TPA == cfg_local_ip_i sampled at the w10 beat; frame reaches w10; rx_error_i == 0 on EOP beat. Any failure latches a sticky `bad` flag.
- FSM:
  - IDLE: wait for accepted beat with SOP -> PARSE (word counter = 1 after it). Beats without SOP are discarded silently and not counted.
  - PARSE: capture fields, evaluate checks. On EOP: all pass -> OUT, else count drop -> IDLE. Once `bad` is set, remaining beats are consumed with no further capture.
  - OUT: upd_valid_o=1, fields stable; on upd_ready_i -> IDLE, cnt_accepted_o += 1.
- SOP while in PARSE: the current frame counts as dropped; the new frame restarts at word 0 on the same beat.
- Single-beat SOP+EOP frame: dropped (short).
- Word counter is 4 bits and saturates at 11.

## Timing

- rx_ready_o = 1 in IDLE/PARSE, 0 in OUT; it is registered-state based and has no combinational path from upd_ready_i.
- upd_valid_o rises the cycle after the accepted EOP beat. It stays high with stable data until the handshake. Minimum two cycles from EOP to next accepted beat.
- Drop counter increments the cycle after the offending EOP/SOP beat.
- Reset (any time, including mid-frame or while OUT): state IDLE, rx_ready_o=1, upd_valid_o=0, upd_ip_o=0, upd_mac_o=0, both counters 0, `bad`=0. A pending update is discarded.

## Structure

- Shared package `lb_pkg`: ETHERTYPE_ARP=16'h0806, ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_OPER_REQ=1, ARP_OPER_REPLY=2, word-index constants, FSM state encoding.
- No sub-module; FSM, capture registers and counters are in one file.

## Test plan

- Valid reply, SPA=10.0.0.5, SHA=02:11:22:33:44:55, TPA=cfg 10.0.0.1, 60-byte frame -> one update {0x0A000005, 0x021122334455}, cnt_accepted=1, upd_valid one cycle after EOP.
- Same frame with upd_ready_i held 0 for 10 cycles -> rx_ready_o=0 and data stable throughout. The next frame is accepted only after the handshake.
- ARP request (oper=1): with ACCEPT_REQUEST=0 -> no update, cnt_dropped=1; with ACCEPT_REQUEST=1 -> update issued.
- Failing frames, one each: ethertype 0x0800; TPA 10.0.0.9; rx_error_i=6'h01 on EOP; EOP at w8 -> no update, cnt_dropped=4.
- SOP injected at w6 of a valid reply, followed by a full valid reply -> cnt_dropped=1, cnt_accepted=1, update carries the second frame's fields.
- rst asserted while upd_valid_o=1 -> all outputs return to reset values immediately. A following valid frame is processed normally.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared constants and state encoding for the ARP learning path.
// Frame word indices count 32-bit beats from SOP.
package lb_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY = 16'd2;

  localparam logic [3:0] W_ETH    = 4'd3;
  localparam logic [3:0] W_PTY    = 4'd4;
  localparam logic [3:0] W_OPER   = 4'd5;
  localparam logic [3:0] W_SHA    = 4'd6;
  localparam logic [3:0] W_SPA    = 4'd7;
  localparam logic [3:0] W_TPA_HI = 4'd9;
  localparam logic [3:0] W_TPA_LO = 4'd10;
  localparam logic [3:0] W_SAT    = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PARSE,
    S_OUT
  } state_t;

endpackage

// File: rtl/arp_reply_parser.sv
// Parses ARP replies from the RX stream and emits (IP, MAC) cache updates.
// One update per accepted frame; everything else bumps the drop counter.
module arp_reply_parser
  import lb_pkg::*;
#(
  parameter bit ACCEPT_REQUEST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_sop_i,
  input  logic        rx_eop_i,
  input  logic [1:0]  rx_empty_i,
  input  logic [5:0]  rx_error_i,
  output logic        rx_ready_o,
  input  logic [31:0] cfg_local_ip_i,
  output logic        upd_valid_o,
  input  logic        upd_ready_i,
  output logic [31:0] upd_ip_o,
  output logic [47:0] upd_mac_o,
  output logic [31:0] cnt_accepted_o,
  output logic [31:0] cnt_dropped_o
);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        bad_q, bad_d;
  logic [15:0] tpa_hi_q, tpa_hi_d;
  logic [31:0] ip_q, ip_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] drop_q, drop_d;

  logic        beat;
  logic [3:0]  idx;
  logic [3:0]  wnext;
  logic [15:0] oper;
  logic        oper_ok;
  logic        fail_now;
  logic        frame_ok;
  logic [1:0]  drop_inc;
  logic        unused_empty;

  // Padding length is irrelevant: all fields sit in fixed words.
  assign unused_empty = ^rx_empty_i;

  assign rx_ready_o     = (state_q != S_OUT);
  assign upd_valid_o    = (state_q == S_OUT);
  assign upd_ip_o       = ip_q;
  assign upd_mac_o      = mac_q;
  assign cnt_accepted_o = acc_q;
  assign cnt_dropped_o  = drop_q;

  assign beat  = rx_valid_i & rx_ready_o;
  assign idx   = rx_sop_i ? 4'd0 : wcnt_q;
  assign wnext = (idx == W_SAT) ? W_SAT : idx + 4'd1;
  assign oper  = rx_data_i[31:16];

  assign oper_ok = (oper == ARP_OPER_REPLY) ||
                   (ACCEPT_REQUEST && (oper == ARP_OPER_REQ));

  always_comb begin
    fail_now = 1'b0;
    case (idx)
      W_ETH:
        fail_now = (rx_data_i != {ETHERTYPE_ARP, ARP_HTYPE_ETH});
      W_PTY:
        fail_now = (rx_data_i !=
                    {ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN});
      W_OPER:
        fail_now = !oper_ok;
      W_TPA_LO:
        fail_now = ({tpa_hi_q, rx_data_i[31:16]} != cfg_local_ip_i);
      default:
        fail_now = 1'b0;
    endcase
  end

  assign frame_ok = !bad_q && !fail_now &&
                    (idx >= W_TPA_LO) && (rx_error_i == 6'd0);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    bad_d    = bad_q;
    tpa_hi_d = tpa_hi_q;
    ip_d     = ip_q;
    mac_d    = mac_q;
    acc_d    = acc_q;
    drop_inc = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        if (beat && rx_sop_i) begin
          bad_d  = 1'b0;
          wcnt_d = 4'd1;
          if (rx_eop_i) drop_inc = 2'd1;
          else          state_d  = S_PARSE;
        end
      end
      S_PARSE: begin
        if (beat) begin
          wcnt_d = wnext;
          if (rx_sop_i) begin
            // Restart: the interrupted frame counts, and so does a
            // new frame that is a lone SOP+EOP beat.
            bad_d    = 1'b0;
            drop_inc = rx_eop_i ? 2'd2 : 2'd1;
            if (rx_eop_i) state_d = S_IDLE;
          end else if (rx_eop_i) begin
            bad_d = 1'b0;
            if (frame_ok) begin
              state_d = S_OUT;
            end else begin
              drop_inc = 2'd1;
              state_d  = S_IDLE;
            end
          end else begin
            bad_d = bad_q | fail_now;
          end
          if (!rx_sop_i && !bad_q) begin
            case (idx)
              W_OPER:   mac_d[47:32] = rx_data_i[15:0];
              W_SHA:    mac_d[31:0]  = rx_data_i;
              W_SPA:    ip_d         = rx_data_i;
              W_TPA_HI: tpa_hi_d     = rx_data_i[15:0];
              default:  ;
            endcase
          end
        end
      end
      S_OUT: begin
        if (upd_ready_i) begin
          acc_d   = acc_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    drop_d = drop_q + 32'(drop_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= 4'd0;
      bad_q    <= 1'b0;
      tpa_hi_q <= 16'd0;
      ip_q     <= 32'd0;
      mac_q    <= 48'd0;
      acc_q    <= 32'd0;
      drop_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      bad_q    <= bad_d;
      tpa_hi_q <= tpa_hi_d;
      ip_q     <= ip_d;
      mac_q    <= mac_d;
      acc_q    <= acc_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_arp_reply_parser.sv
// Directed bench for arp_reply_parser: replies, requests, bad frames,
// SOP restart, backpressure and reset while an update is pending.
module tb_arp_reply_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rx_data = 32'd0;
  logic        rx_valid = 1'b0;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;
  logic [1:0]  rx_empty = 2'd0;
  logic [5:0]  rx_error = 6'd0;
  logic        rx_ready_o;
  logic [31:0] cfg_ip = 32'h0A000001;
  logic        upd_valid_o;
  logic        upd_ready = 1'b0;
  logic [31:0] upd_ip_o;
  logic [47:0] upd_mac_o;
  logic [31:0] cnt_acc_o;
  logic [31:0] cnt_drop_o;

  logic        en2 = 1'b0;
  logic        rx_valid2;
  logic        rx_ready2;
  logic        upd_valid2;
  logic [31:0] upd_ip2;
  logic [47:0] upd_mac2;
  logic [31:0] cnt_acc2;
  logic [31:0] cnt_drop2;

  logic [31:0] fw [15];
  int errors = 0;
  int checks = 0;

  assign rx_valid2 = rx_valid & en2;

  always #5 clk = ~clk;

  arp_reply_parser dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_sop_i(rx_sop), .rx_eop_i(rx_eop),
    .rx_empty_i(rx_empty), .rx_error_i(rx_error),
    .rx_ready_o(rx_ready_o), .cfg_local_ip_i(cfg_ip),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready),
    .upd_ip_o(upd_ip_o), .upd_mac_o(upd_mac_o),
    .cnt_accepted_o(cnt_acc_o), .cnt_dropped_o(cnt_drop_o)
  );

  arp_reply_parser #(.ACCEPT_REQUEST(1'b1)) dut_req (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid2),
    .rx_sop_i(rx_sop), .rx_eop_i(rx_eop),
    .rx_empty_i(rx_empty), .rx_error_i(rx_error),
    .rx_ready_o(rx_ready2), .cfg_local_ip_i(cfg_ip),
    .upd_valid_o(upd_valid2), .upd_ready_i(upd_ready),
    .upd_ip_o(upd_ip2), .upd_mac_o(upd_mac2),
    .cnt_accepted_o(cnt_acc2), .cnt_dropped_o(cnt_drop2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [15:0] et, input logic [15:0] op,
                       input logic [47:0] sha, input logic [31:0] spa,
                       input logic [31:0] tpa);
    fw[0]  = 32'hFFFFFFFF;
    fw[1]  = 32'hFFFF0266;
    fw[2]  = 32'h77889900;
    fw[3]  = {et, 16'h0001};
    fw[4]  = 32'h08000604;
    fw[5]  = {op, sha[47:32]};
    fw[6]  = sha[31:0];
    fw[7]  = spa;
    fw[8]  = 32'h00000000;
    fw[9]  = {16'h0000, tpa[31:16]};
    fw[10] = {tpa[15:0], 16'h0000};
    for (int i = 11; i < 15; i++) fw[i] = 32'd0;
  endtask

  // Returns on the falling edge one cycle after the last beat.
  task automatic send(input int n, input bit eop, input logic [5:0] err);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int g = 0; g < 20 && !rx_ready_o; g++) @(negedge clk);
      if (!rx_ready_o) begin
        errors++;
        checks++;
        $error("FAIL rx_ready_timeout observed=0 expected=1");
      end
      rx_data  = fw[i];
      rx_valid = 1'b1;
      rx_sop   = (i == 0);
      rx_eop   = eop && (i == n - 1);
      rx_error = (eop && i == n - 1) ? err : 6'd0;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
    rx_error = 6'd0;
  endtask

  task automatic handshake();
    upd_ready = 1'b1;
    @(negedge clk);
    upd_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", rx_ready_o, 1);
    chk("rst_valid", upd_valid_o, 0);
    chk("rst_ip", upd_ip_o, 0);
    chk("rst_mac", upd_mac_o, 0);
    chk("rst_acc", cnt_acc_o, 0);
    chk("rst_drop", cnt_drop_o, 0);

    // Valid reply, held off for 10 cycles.
    build(16'h0806, 16'd2, 48'h021122334455, 32'h0A000005, 32'h0A000001);
    send(15, 1'b1, 6'd0);
    chk("t1_valid_lat", upd_valid_o, 1);
    chk("t1_ip", upd_ip_o, 32'h0A000005);
    chk("t1_mac", upd_mac_o, 48'h021122334455);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_valid", upd_valid_o, 1);
      chk("hold_ready", rx_ready_o, 0);
      chk("hold_ip", upd_ip_o, 32'h0A000005);
      chk("hold_mac", upd_mac_o, 48'h021122334455);
    end
    handshake();
    chk("t1_valid_done", upd_valid_o, 0);
    chk("t1_ready_back", rx_ready_o, 1);
    chk("t1_acc", cnt_acc_o, 1);
    chk("t1_drop", cnt_drop_o, 0);

    // Request: dropped by default build, learned with ACCEPT_REQUEST.
    build(16'h0806, 16'd1, 48'h02AABBCCDD01, 32'h0A000063, 32'h0A000001);
    en2 = 1'b1;
    send(15, 1'b1, 6'd0);
    en2 = 1'b0;
    chk("req_valid0", upd_valid_o, 0);
    chk("req_drop0", cnt_drop_o, 1);
    chk("req_valid1", upd_valid2, 1);
    chk("req_ip1", upd_ip2, 32'h0A000063);
    chk("req_mac1", upd_mac2, 48'h02AABBCCDD01);
    handshake();
    chk("req_acc1", cnt_acc2, 1);
    chk("req_valid1_done", upd_valid2, 0);

    // Failing frames.
    build(16'h0800, 16'd2, 48'h021122334455, 32'h0A000005, 32'h0A000001);
    send(15, 1'b1, 6'd0);
    chk("eth_valid", upd_valid_o, 0);
    chk("eth_drop", cnt_drop_o, 2);
    build(16'h0806, 16'd2, 48'h021122334455, 32'h0A000005, 32'h0A000009);
    send(15, 1'b1, 6'd0);
    chk("tpa_valid", upd_valid_o, 0);
    chk("tpa_drop", cnt_drop_o, 3);
    build(16'h0806, 16'd2, 48'h021122334455, 32'h0A000005, 32'h0A000001);
    send(15, 1'b1, 6'h01);
    chk("err_valid", upd_valid_o, 0);
    chk("err_drop", cnt_drop_o, 4);
    send(9, 1'b1, 6'd0);
    chk("short_valid", upd_valid_o, 0);
    chk("short_drop", cnt_drop_o, 5);
    send(1, 1'b1, 6'd0);
    chk("single_valid", upd_valid_o, 0);
    chk("single_drop", cnt_drop_o, 6);
    chk("fail_acc", cnt_acc_o, 1);

    // SOP at w6 of a reply, then a complete reply.
    send(6, 1'b0, 6'd0);
    build(16'h0806, 16'd2, 48'h02AABBCCDDEE, 32'h0A000007, 32'h0A000001);
    send(15, 1'b1, 6'd0);
    chk("sop_valid", upd_valid_o, 1);
    chk("sop_ip", upd_ip_o, 32'h0A000007);
    chk("sop_mac", upd_mac_o, 48'h02AABBCCDDEE);
    chk("sop_drop", cnt_drop_o, 7);
    handshake();
    chk("sop_acc", cnt_acc_o, 2);

    // Reset with an update pending.
    build(16'h0806, 16'd2, 48'h021122334455, 32'h0A000005, 32'h0A000001);
    send(15, 1'b1, 6'd0);
    chk("pre_rst_valid", upd_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", upd_valid_o, 0);
    chk("mid_rst_ready", rx_ready_o, 1);
    chk("mid_rst_ip", upd_ip_o, 0);
    chk("mid_rst_mac", upd_mac_o, 0);
    chk("mid_rst_acc", cnt_acc_o, 0);
    chk("mid_rst_drop", cnt_drop_o, 0);
    @(negedge clk);
    rst = 1'b0;
    build(16'h0806, 16'd2, 48'h0200DEADBEEF, 32'hC0A80102, 32'h0A000001);
    send(15, 1'b1, 6'd0);
    chk("post_valid", upd_valid_o, 1);
    chk("post_ip", upd_ip_o, 32'hC0A80102);
    chk("post_mac", upd_mac_o, 48'h0200DEADBEEF);
    handshake();
    chk("post_acc", cnt_acc_o, 1);
    chk("post_drop", cnt_drop_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
